npc_mem_arbiter: RTL and testbench

- Shares the single physical memory port between the instruction-fetch path (IFU) and the load/store path (LSU) of the npc core.
- Sits between the core and the pmem/DPI bridge and replaces the direct combinational memory reads.
- Uses valid/ready request handshakes, one outstanding transaction, round-robin or LSU-priority arbitration, and a response watchdog.

---
 rtl/npc_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_npc_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: shares the single memory port between IFU and LSU with one
// outstanding transaction, round-robin or LSU-priority grant and a response watchdog.
module npc_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t            state_r;
    logic              last_lsu_r;
    logic              owner_lsu_r;
    logic [15:0]       cnt_r;
    logic              grant_ifu_s;
    logic              grant_lsu_s;
    logic [DATA_W-1:0] resp_data_s;
    logic              resp_err_s;

    // Grant is offered only while idle; gating with reset keeps ready low during async reset
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if ((state_r == IDLE) && !reset) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (RR_EN != 0) begin
                    grant_lsu_s = !last_lsu_r;
                    grant_ifu_s = last_lsu_r;
                end else begin
                    grant_lsu_s = 1'b1;
                end
            end else begin
                grant_ifu_s = ifu_req_valid;
                grant_lsu_s = lsu_req_valid;
            end
        end else begin
            grant_ifu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    assign ifu_req_ready = grant_ifu_s;
    assign lsu_req_ready = grant_lsu_s;

    // Response payload: a real response beats a coinciding timeout; stores return zero
    always_comb begin
        resp_data_s = {DATA_W{1'b0}};
        resp_err_s  = 1'b1;
        if (mem_resp_valid) begin
            resp_err_s = 1'b0;
            if (!mem_wen) begin
                resp_data_s = mem_rdata;
            end else begin
                resp_data_s = {DATA_W{1'b0}};
            end
        end else begin
            resp_data_s = {DATA_W{1'b0}};
            resp_err_s  = 1'b1;
        end
    end

    // Transaction FSM with registered memory-side and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            last_lsu_r     <= 1'b0;
            owner_lsu_r    <= 1'b0;
            cnt_r          <= 16'd0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= {ADDR_W{1'b0}};
            mem_wen        <= 1'b0;
            mem_wdata      <= {DATA_W{1'b0}};
            mem_wmask      <= 4'h0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= {DATA_W{1'b0}};
            ifu_err        <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= {DATA_W{1'b0}};
            lsu_err        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_lsu_s) begin
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wen ? lsu_wmask : 4'h0;
                        owner_lsu_r   <= 1'b1;
                        last_lsu_r    <= 1'b1;
                        mem_req_valid <= 1'b1;
                        state_r       <= REQ;
                    end else if (grant_ifu_s) begin
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= {DATA_W{1'b0}};
                        mem_wmask     <= 4'h0;
                        owner_lsu_r   <= 1'b0;
                        last_lsu_r    <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state_r       <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt_r         <= 16'd0;
                        state_r       <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 16'd1;
                    if (mem_resp_valid || (cnt_r == LAST_WAIT)) begin
                        if (owner_lsu_r) begin
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= resp_data_s;
                            lsu_err        <= resp_err_s;
                        end else begin
                            ifu_resp_valid <= 1'b1;
                            ifu_rdata      <= resp_data_s;
                            ifu_err        <= resp_err_s;
                        end
                        state_r <= RESP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    ifu_resp_valid <= 1'b0;
                    lsu_resp_valid <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Bench for npc_mem_arbiter: two instances (round-robin and LSU-priority) share stimulus;
// a transaction-level model predicts every output each cycle.
module tb_npc_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, lsu_req_valid, lsu_wen, mem_req_ready, mem_resp_valid;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [3:0]  lsu_wmask;
    logic [1:0]  ifu_ready, lsu_ready, ifu_rv, lsu_rv, ifu_e, lsu_e, mreq_v, m_wen;
    logic [31:0] ifu_rd [2];
    logic [31:0] lsu_rd [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wmask [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(g == 0 ? 1 : 0), .TIMEOUT(TO)) dut (
            .clk(clk), .reset(reset),
            .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_ready[g]), .ifu_addr(ifu_addr),
            .ifu_resp_valid(ifu_rv[g]), .ifu_rdata(ifu_rd[g]), .ifu_err(ifu_e[g]),
            .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_ready[g]), .lsu_addr(lsu_addr),
            .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
            .lsu_resp_valid(lsu_rv[g]), .lsu_rdata(lsu_rd[g]), .lsu_err(lsu_e[g]),
            .mem_req_valid(mreq_v[g]), .mem_req_ready(mem_req_ready), .mem_addr(m_addr[g]),
            .mem_wen(m_wen[g]), .mem_wdata(m_wdata[g]), .mem_wmask(m_wmask[g]),
            .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state and per-cycle expectations (index = instance)
    bit          last_lsu [2];
    bit          x_ifu_rdy [2], x_lsu_rdy [2], x_ifu_rv [2], x_lsu_rv [2], x_ifu_e [2], x_lsu_e [2], x_wen [2];
    bit          x_mreq;
    logic [31:0] x_ifu_rd [2], x_lsu_rd [2], x_addr [2], x_wdata [2];
    logic [3:0]  x_wmask [2];

    // observations of instance 0 used by the literal checks
    int          obs_grant_cyc, obs_resp_cyc, obs_first_mreq_cyc, obs_last_mreq_cyc, obs_mreq_n;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wmask;
    logic        obs_wen;
    bit          prev_mreq = 1'b0;
    int          win0[$];
    int          win1[$];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // compare process: every cycle, every output of both instances against the model
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("ifu_req_ready", d, 32'(ifu_ready[d]), 32'(x_ifu_rdy[d]));
                chk("lsu_req_ready", d, 32'(lsu_ready[d]), 32'(x_lsu_rdy[d]));
                chk("mem_req_valid", d, 32'(mreq_v[d]), 32'(x_mreq));
                chk("ifu_resp_valid", d, 32'(ifu_rv[d]), 32'(x_ifu_rv[d]));
                chk("lsu_resp_valid", d, 32'(lsu_rv[d]), 32'(x_lsu_rv[d]));
                chk("ifu_rdata", d, ifu_rd[d], x_ifu_rd[d]);
                chk("ifu_err", d, 32'(ifu_e[d]), 32'(x_ifu_e[d]));
                chk("lsu_rdata", d, lsu_rd[d], x_lsu_rd[d]);
                chk("lsu_err", d, 32'(lsu_e[d]), 32'(x_lsu_e[d]));
                if (x_mreq) begin
                    chk("mem_addr", d, m_addr[d], x_addr[d]);
                    chk("mem_wen", d, 32'(m_wen[d]), 32'(x_wen[d]));
                    chk("mem_wmask", d, 32'(m_wmask[d]), 32'(x_wmask[d]));
                    if (x_wen[d]) chk("mem_wdata", d, m_wdata[d], x_wdata[d]);
                end
            end
        end
        if (ifu_ready[0] || lsu_ready[0]) obs_grant_cyc = cyc;
        if (lsu_ready[0]) win0.push_back(1); else if (ifu_ready[0]) win0.push_back(0);
        if (lsu_ready[1]) win1.push_back(1); else if (ifu_ready[1]) win1.push_back(0);
        if (mreq_v[0]) begin
            if (!prev_mreq) begin
                obs_mreq_n = 0;
                obs_first_mreq_cyc = cyc;
            end
            obs_mreq_n++;
            obs_last_mreq_cyc = cyc;
            obs_addr = m_addr[0]; obs_wen = m_wen[0]; obs_wdata = m_wdata[0]; obs_wmask = m_wmask[0];
        end
        prev_mreq = mreq_v[0];
        if (ifu_rv[0] || lsu_rv[0]) obs_resp_cyc = cyc;
    end

    task automatic quiet();
        x_mreq = 1'b0;
        for (int d = 0; d < 2; d++) begin
            x_ifu_rdy[d] = 1'b0; x_lsu_rdy[d] = 1'b0; x_ifu_rv[d] = 1'b0; x_lsu_rv[d] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = $urandom;
            quiet();
        end
    endtask

    task automatic settle();
        idle(1);
        #3;
    endtask

    // one transaction: grant cycle, acc+1 request cycles, wait cycles, response cycle.
    // rsp >= TO means the memory never answers; abort fires reset in the first wait cycle.
    task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                           input bit wen, input logic [31:0] wd, input logic [3:0] wm,
                           input int acc, input int rsp, input logic [31:0] rd, input bit abort);
        bit w [2];
        bit tmo;
        int nw;
        tmo = (rsp >= TO);
        nw  = tmo ? TO : rsp + 1;
        @(negedge clk);
        ifu_req_valid = iv; lsu_req_valid = lv; ifu_addr = ia; lsu_addr = la;
        lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = $urandom;
        quiet();
        for (int d = 0; d < 2; d++) begin
            if (iv && lv) w[d] = (d == 0) ? !last_lsu[d] : 1'b1;
            else          w[d] = lv;
            last_lsu[d]  = w[d];
            x_ifu_rdy[d] = !w[d];
            x_lsu_rdy[d] = w[d];
            x_addr[d]    = w[d] ? la : ia;
            x_wen[d]     = w[d] && wen;
            x_wdata[d]   = wd;
            x_wmask[d]   = (w[d] && wen) ? wm : 4'h0;
        end
        for (int k = 0; k <= acc; k++) begin
            @(negedge clk);
            quiet();
            x_mreq = 1'b1;
            mem_req_ready = (k == acc);
            mem_rdata = $urandom;
        end
        for (int k = 0; k < nw; k++) begin
            @(negedge clk);
            quiet();
            mem_req_ready  = 1'b0;
            mem_resp_valid = !tmo && (k == rsp);
            mem_rdata      = mem_resp_valid ? rd : $urandom;
            if (abort) begin
                #4;
                reset = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("rst_ifu_ready", d, 32'(ifu_ready[d]), 32'd0);
                    chk("rst_lsu_ready", d, 32'(lsu_ready[d]), 32'd0);
                    chk("rst_mem_req_valid", d, 32'(mreq_v[d]), 32'd0);
                    chk("rst_mem_addr", d, m_addr[d], 32'd0);
                    chk("rst_mem_wen", d, 32'(m_wen[d]), 32'd0);
                    chk("rst_mem_wdata", d, m_wdata[d], 32'd0);
                    chk("rst_mem_wmask", d, 32'(m_wmask[d]), 32'd0);
                    chk("rst_resp_valid", d, 32'({ifu_rv[d], lsu_rv[d]}), 32'd0);
                    chk("rst_ifu_rdata", d, ifu_rd[d], 32'd0);
                    chk("rst_lsu_rdata", d, lsu_rd[d], 32'd0);
                    chk("rst_err", d, 32'({ifu_e[d], lsu_e[d]}), 32'd0);
                    last_lsu[d] = 1'b0;
                    x_ifu_rd[d] = 32'd0; x_lsu_rd[d] = 32'd0; x_ifu_e[d] = 1'b0; x_lsu_e[d] = 1'b0;
                end
                quiet();
                return;
            end
        end
        @(negedge clk);
        quiet();
        mem_resp_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (w[d]) begin
                x_lsu_rv[d] = 1'b1;
                x_lsu_rd[d] = (tmo || wen) ? 32'd0 : rd;
                x_lsu_e[d]  = tmo;
            end else begin
                x_ifu_rv[d] = 1'b1;
                x_ifu_rd[d] = tmo ? 32'd0 : rd;
                x_ifu_e[d]  = tmo;
            end
        end
    endtask

    initial begin : stim
        int b0, b1;
        int e0 [4];
        int e1 [4];
        bit iv, lv;
        reset = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; ifu_addr = 32'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
        lsu_wmask = 4'h0; mem_rdata = 32'd0;
        for (int d = 0; d < 2; d++) begin
            last_lsu[d] = 1'b0; x_ifu_rd[d] = 32'd0; x_lsu_rd[d] = 32'd0;
            x_ifu_e[d] = 1'b0; x_lsu_e[d] = 1'b0; x_wen[d] = 1'b0;
            x_addr[d] = 32'd0; x_wdata[d] = 32'd0; x_wmask[d] = 4'h0;
        end
        quiet();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // IFU fetch at minimum latency
        run_txn(1'b1, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'h00100073, 1'b0);
        settle();
        chk("t1_latency", 0, 32'(obs_resp_cyc - obs_grant_cyc), 32'd3);
        chk("t1_req_cycle", 0, 32'(obs_first_mreq_cyc - obs_grant_cyc), 32'd1);
        chk("t1_mem_addr", 0, obs_addr, 32'h80000000);
        chk("t1_mem_wen", 0, 32'(obs_wen), 32'd0);
        chk("t1_ifu_rdata", 0, ifu_rd[0], 32'h00100073);
        chk("t1_ifu_err", 0, 32'(ifu_e[0]), 32'd0);

        // three contended rounds, then IFU alone
        b0 = win0.size(); b1 = win1.size();
        e0 = '{1, 0, 1, 0};
        e1 = '{1, 1, 1, 0};
        for (int r = 0; r < 3; r++)
            run_txn(1'b1, 1'b1, 32'h80000100 + 32'(r), 32'h80002000 + 32'(r), 1'b0, 32'h0, 4'h0,
                    0, 0, 32'h11110000 + 32'(r), 1'b0);
        run_txn(1'b1, 1'b0, 32'h80000200, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1, 32'h22220000, 1'b0);
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 0, 32'(win0[b0 + i]), 32'(e0[i]));
            chk("prio_order", 1, 32'(win1[b1 + i]), 32'(e1[i]));
        end

        // store with accept delayed by 5 cycles
        run_txn(1'b0, 1'b1, 32'h0, 32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF, 5, 0, 32'h12345678, 1'b0);
        settle();
        chk("t3_req_cycles", 0, 32'(obs_mreq_n), 32'd6);
        chk("t3_mem_addr", 0, obs_addr, 32'h80001000);
        chk("t3_mem_wdata", 0, obs_wdata, 32'hDEADBEEF);
        chk("t3_mem_wmask", 0, 32'(obs_wmask), 32'hF);
        chk("t3_mem_wen", 0, 32'(obs_wen), 32'd1);
        chk("t3_lsu_rdata", 0, lsu_rd[0], 32'd0);
        chk("t3_lsu_err", 0, 32'(lsu_e[0]), 32'd0);

        // watchdog expiry, then a normal IFU fetch
        run_txn(1'b0, 1'b1, 32'h0, 32'h80003000, 1'b0, 32'h0, 4'h0, 0, TO, 32'h33333333, 1'b0);
        settle();
        chk("t4_timeout_cycles", 0, 32'(obs_resp_cyc - obs_last_mreq_cyc - 1), 32'd8);
        chk("t4_lsu_err", 0, 32'(lsu_e[0]), 32'd1);
        chk("t4_lsu_rdata", 0, lsu_rd[0], 32'd0);
        run_txn(1'b1, 1'b0, 32'h80000300, 32'h0, 1'b0, 32'h0, 4'h0, 1, 2, 32'h44444444, 1'b0);
        settle();
        chk("t4_next_rdata", 0, ifu_rd[0], 32'h44444444);
        chk("t4_next_err", 0, 32'(ifu_e[0]), 32'd0);

        // response on the timeout cycle wins
        run_txn(1'b0, 1'b1, 32'h0, 32'h80004000, 1'b0, 32'h0, 4'h0, 0, TO - 1, 32'hCAFEF00D, 1'b0);
        settle();
        chk("t5_wait_cycles", 0, 32'(obs_resp_cyc - obs_last_mreq_cyc - 1), 32'd8);
        chk("t5_lsu_err", 0, 32'(lsu_e[0]), 32'd0);
        chk("t5_lsu_rdata", 0, lsu_rd[0], 32'hCAFEF00D);

        // async reset in WAIT, then contended request after release
        run_txn(1'b1, 1'b1, 32'h80000400, 32'h80005000, 1'b0, 32'h0, 4'h0, 0, 3, 32'h55555555, 1'b1);
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        b0 = win0.size(); b1 = win1.size();
        run_txn(1'b1, 1'b1, 32'h80000500, 32'h80006000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h66666666, 1'b0);
        settle();
        chk("t6_first_grant", 0, 32'(win0[b0]), 32'd1);
        chk("t6_first_grant", 1, 32'(win1[b1]), 32'd1);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 9), $urandom, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(2);
        @(negedge clk);
        #3;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
